// File: rtl/bit_count_scheduler.sv
// Round-robin scheduler sharing one shift/accumulate popcount engine among N_REQ requesters.
// Latency: done_vec rises (highest set bit index + 2) cycles after ack; requests are not sampled while busy.
module bit_count_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     data,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(WIDTH+1)-1:0] result,
    output logic [N_REQ-1:0]           done_vec,
    output logic                       busy
);
    localparam int CW = $clog2(WIDTH+1);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_reg;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     ptr_nxt;

    logic              grant_vld;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand_idx;
    logic [IW:0]       cand;
    logic [N_REQ-1:0]  grant_oh;
    logic [N_REQ-1:0]  owner_oh;
    logic [WIDTH-1:0]  operand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_operand
            assign operand[gi] = data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Walk offsets from the far end so the smallest offset from ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            cand_idx = cand[IW-1:0];
            if (req[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant_oh = N_REQ'(1) << grant_idx;
    assign owner_oh = N_REQ'(1) << owner;
    assign ptr_nxt  = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_vld) state_nxt = S_COUNT;
            S_COUNT: if (a_reg == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // ack and done_vec default low so each is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            cnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            ack      <= '0;
            result   <= '0;
            done_vec <= '0;
        end else begin
            ack      <= '0;
            done_vec <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        a_reg <= operand[grant_idx];
                        cnt   <= '0;
                        owner <= grant_idx;
                        ack   <= grant_oh;
                        ptr   <= ptr_nxt;
                    end
                end
                S_COUNT: begin
                    if (a_reg == '0) begin
                        result   <= cnt;
                        done_vec <= owner_oh;
                    end else begin
                        cnt   <= cnt + CW'(a_reg[0]);
                        a_reg <= a_reg >> 1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_count_scheduler.sv
// Bench for bit_count_scheduler: directed scenarios with literal expectations,
// then randomized requester traffic checked every cycle against a transaction-level model.
module tb_bit_count_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  data = '0;
    logic [N-1:0]    ack;
    logic [CW-1:0]   result;
    logic [N-1:0]    done_vec;
    logic            busy;

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    bit_count_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .ack(ack), .result(result), .done_vec(done_vec), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int span(input logic [W-1:0] v);
        int s = 0;
        for (int b = 0; b < W; b++) if (v[b]) s = b + 1;
        return s;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        int r = $urandom_range(0, 3);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return W'($urandom);
    endfunction

    // Transaction model: a job is granted, runs for span+1 cycles, reports popcount, then one done cycle.
    int           m_phase = 0;
    int           m_left  = 0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    int           m_pend  = 0;
    int           m_g;
    logic [W-1:0] m_op;
    logic [N-1:0] m_ack    = '0;
    logic [N-1:0] m_done   = '0;
    logic [CW-1:0] m_result = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_ack = '0; m_done = '0; m_result = '0;
        end else begin
            m_ack = '0;
            case (m_phase)
                0: if (req != '0) begin
                    m_g = -1;
                    for (int k = 0; k < N; k++)
                        if (m_g < 0 && req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                    m_ack[m_g] = 1'b1;
                    m_owner = m_g;
                    m_ptr   = (m_g + 1) % N;
                    m_op    = data[m_g*W +: W];
                    m_pend  = $countones(m_op);
                    m_left  = span(m_op) + 1;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_done = '0;
                        m_done[m_owner] = 1'b1;
                        m_result = CW'(m_pend);
                    end
                end
                default: begin
                    m_done  = '0;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ack", 32'(ack), 32'(m_ack));
            check("model_done_vec", 32'(done_vec), 32'(m_done));
            check("model_result", 32'(result), 32'(m_result));
            check("model_busy", 32'(busy), 32'(m_phase != 0));
        end
    end

    task automatic run_job(input int i, input logic [W-1:0] d, input int exp_lat, input int exp_res);
        int  lat;
        bit  got;
        @(negedge clk);
        data[i*W +: W] = d;
        req[i] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ack != '0) begin got = 1'b1; break; end
        end
        check("job_ack_seen", 32'(got), 1);
        check("job_ack_value", 32'(ack), 32'(1) << i);
        check("job_busy_at_ack", 32'(busy), 1);
        req[i] = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            lat++;
            if (done_vec != '0) begin got = 1'b1; break; end
        end
        check("job_done_seen", 32'(got), 1);
        check("job_done_latency", 32'(lat), 32'(exp_lat));
        check("job_done_owner", 32'(done_vec), 32'(1) << i);
        check("job_result", 32'(result), 32'(exp_res));
        @(negedge clk);
        check("job_busy_after_done", 32'(busy), 0);
        check("job_done_cleared", 32'(done_vec), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!busy) begin got = 1'b1; break; end
        end
        check("wait_idle", 32'(got), 1);
    endtask

    logic [N-1:0]  ack_seq  [4];
    logic [N-1:0]  done_seq [4];
    logic [CW-1:0] res_seq  [4];
    int            ack_cyc  [4];
    int            done_cyc [4];
    int            na, nd;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_ack", 32'(ack), 0);
        check("reset_done_vec", 32'(done_vec), 0);
        check("reset_result", 32'(result), 0);
        check("reset_busy", 32'(busy), 0);

        run_job(0, 8'b0010_0100, 7, 2);
        run_job(2, 8'h00, 1, 0);
        run_job(1, 8'hFF, 9, 8);

        // All four requesters at once, each dropping its line at its own ack.
        pulse_reset();
        data = {8'h0F, 8'h07, 8'h03, 8'h01};
        req = 4'hF;
        na = 0; nd = 0;
        for (int c = 0; c < 200 && nd < 4; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                if (na < 4) begin ack_seq[na] = ack; ack_cyc[na] = c; end
                na++;
                req = req & ~ack;
            end
            if (done_vec != '0) begin
                if (nd < 4) begin done_seq[nd] = done_vec; res_seq[nd] = result; done_cyc[nd] = c; end
                nd++;
            end
        end
        check("all4_ack_count", 32'(na), 4);
        check("all4_done_count", 32'(nd), 4);
        for (int k = 0; k < 4; k++) begin
            check("all4_ack_order", 32'(ack_seq[k]), 32'(1) << k);
            check("all4_done_owner", 32'(done_seq[k]), 32'(1) << k);
            check("all4_result", 32'(res_seq[k]), 32'(k + 1));
        end
        for (int k = 0; k < 3; k++)
            check("all4_idle_gap", 32'(ack_cyc[k+1] - done_cyc[k]), 2);

        // Two requesters held continuously must alternate.
        wait_idle();
        data[0*W +: W] = 8'h01;
        data[1*W +: W] = 8'h01;
        req = 4'b0011;
        na = 0;
        for (int c = 0; c < 200 && na < 4; c++) begin
            @(negedge clk);
            if (ack != '0) begin ack_seq[na] = ack; na++; end
        end
        req = '0;
        check("fair_ack_count", 32'(na), 4);
        check("fair_grant0", 32'(ack_seq[0]), 32'h1);
        check("fair_grant1", 32'(ack_seq[1]), 32'h2);
        check("fair_grant2", 32'(ack_seq[2]), 32'h1);
        check("fair_grant3", 32'(ack_seq[3]), 32'h2);
        wait_idle();

        // Abort a long job with reset on its third counting cycle.
        @(negedge clk);
        data[0*W +: W] = 8'h80;
        req = 4'b0001;
        na = 0;
        for (int c = 0; c < 50 && na == 0; c++) begin
            @(negedge clk);
            if (ack != '0) na = 1;
        end
        check("abort_ack_seen", 32'(na), 1);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_result", 32'(result), 0);
        check("abort_done_vec", 32'(done_vec), 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_no_late_done", 32'(done_vec), 0);
        end
        data[1*W +: W] = 8'h01;
        req = 4'b0011;
        na = 0;
        for (int c = 0; c < 50 && na == 0; c++) begin
            @(negedge clk);
            if (ack != '0) begin na = 1; ack_seq[0] = ack; end
        end
        check("ptr_reset_grant", 32'(ack_seq[0]), 32'h1);
        req[0] = 1'b0;
        for (int c = 0; c < 50 && req != '0; c++) begin
            @(negedge clk);
            req = req & ~ack;
        end
        wait_idle();

        // Reset coinciding with a request: no grant.
        @(negedge clk);
        reset = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        check("reset_wins_ack", 32'(ack), 0);
        check("reset_wins_busy", 32'(busy), 0);
        reset = 1'b0;
        req = '0;
        wait_idle();

        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        req[i] = 1'b0;
                    end
                end else begin
                    data[i*W +: W] = rand_operand();
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
